// File: rtl/ldl_crc_stream.sv
// Streaming CRC engine: folds one DW-bit beat per cycle into an accumulator, finalizes on the last beat.
// Latency: crc_valid rises the cycle after the last beat is accepted; back-to-back results have no bubble.
// Backpressure: s_ready drops while a result is held and crc_ready is low, and whenever clear is high.
module ldl_crc_stream #(
    parameter int            DW      = 32,
    parameter int            CW      = 32,
    parameter logic [CW-1:0] POLY    = 32'h04C11DB7,
    parameter logic [CW-1:0] INIT    = 32'hFFFFFFFF,
    parameter logic [CW-1:0] XOROUT  = 32'hFFFFFFFF,
    parameter bit            REFIN   = 1'b1,
    parameter bit            REFOUT  = 1'b1,
    parameter logic [CW-1:0] RESIDUE = 32'h2144DF1C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic [DW/8-1:0] s_keep,
    input  logic            s_last,
    output logic            crc_valid,
    input  logic            crc_ready,
    output logic [CW-1:0]   crc_out,
    output logic            crc_match
);

    localparam int NB = DW / 8;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   acc;
    logic [CW-1:0]   acc_next;
    logic [CW-1:0]   fin;
    logic [NB-1:0]   byte_en;
    logic            accept;

    // Bit-serial LFSR unrolled over every enabled byte; a disabled byte contributes no shifts.
    function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] a,
                                               input logic [DW-1:0] d,
                                               input logic [NB-1:0] en);
        logic [CW-1:0] c;
        logic          fb;
        c = a;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) begin
                for (int j = 0; j < 8; j++) begin
                    fb = c[CW-1] ^ (REFIN ? d[8*i+j] : d[8*i+7-j]);
                    c  = {c[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] rev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[CW-1-i];
        end
        return r;
    endfunction

    assign byte_en   = s_last ? s_keep : '1;
    assign acc_next  = crc_step(acc, s_data, byte_en);
    assign fin       = (REFOUT ? rev(acc_next) : acc_next) ^ XOROUT;
    assign s_ready   = !clear && ((state == ACCUM) || crc_ready);
    assign accept    = s_valid && s_ready;
    assign crc_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= INIT;
            crc_out   <= '0;
            crc_match <= 1'b0;
        end else if (clear) begin
            state <= ACCUM;
            acc   <= INIT;
        end else begin
            if (state == HOLD && crc_ready) begin
                state <= ACCUM;
            end
            // A last beat accepted while the old result drains keeps HOLD and replaces the result.
            if (accept) begin
                if (s_last) begin
                    acc       <= INIT;
                    crc_out   <= fin;
                    crc_match <= (fin == RESIDUE);
                    state     <= HOLD;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

`ifndef SYNTHESIS
    localparam logic [NB-1:0] KEEP_ONE = 1;

    keep_contig_a: assert property (@(posedge clk) disable iff (rst)
        (s_valid && s_ready && s_last) |-> ((s_keep & (s_keep + KEEP_ONE)) == '0))
        else $error("non-contiguous s_keep on last beat");
`endif

endmodule

// File: doc/ldl_crc_stream.md
Name: ldl_crc_stream

Overview:
- Parametrised, pipelined CRC engine that accumulates a CRC over a streamed message, one DW-bit beat per cycle.
- Supports a partial final beat through byte enables and configurable INIT, XOROUT, input reflection and output reflection.
- Presents the finished CRC on a valid/ready result port, plus a residue-check flag for receive-side FCS validation.
- Generalises the fixed 8-bit CRC-32 update function to any data width and polynomial. Sits between packet framers and MAC/link logic.

Parameters:
- DW, 32, data beat width in bits; multiple of 8, range 8..512.
- CW, 32, CRC width in bits, range 8..64.
- POLY, 32'h04C11DB7, generator polynomial in normal form, without the x^CW term.
- INIT, 32'hFFFFFFFF, accumulator value at start of each message.
- XOROUT, 32'hFFFFFFFF, value XORed into the final CRC.
- REFIN, 1, 1 = each byte is processed LSB-first.
- REFOUT, 1, 1 = the final register is bit-reversed before the XOROUT step.
- RESIDUE, 32'h2144DF1C, expected crc_out when the message includes its own FCS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clear  in  1  synchronous abort: accumulator returns to INIT and any pending result is dropped
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DW  beat data; byte 0 = s_data[7:0] and is processed first
- s_keep  in  DW/8  byte enables; honoured only on the last beat and must be contiguous from byte 0
- s_last  in  1  final beat of the message
- crc_valid  out  1  result valid
- crc_ready  in  1  result consumed when crc_valid && crc_ready
- crc_out  out  CW  final CRC, after reflection and XOROUT
- crc_match  out  1  (crc_out == RESIDUE); qualified by crc_valid

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: accumulator = INIT, crc_valid = 0, crc_out = 0, crc_match = 0, s_ready = 1.
- States:
  - ACCUM: s_ready = 1.
  - HOLD: crc_valid = 1; s_ready = crc_ready, so a new beat may be accepted in the same cycle the result is consumed.
- Update rule: combinational unrolled LFSR over the enabled bytes in byte order. With REFIN = 1, bit 0 of each byte enters first; with REFIN = 0, bit 7 enters first. Registered once per accepted beat.
- Non-last beats: all DW/8 bytes are processed and s_keep is ignored.
- Last beat: only bytes with keep = 1 are processed. keep = 0 means the message ends with no further bytes.
- Transitions:
  - On an accepted last beat, the result register loads finalize(acc) = (REFOUT ? rev(acc) : acc) ^ XOROUT, and crc_match loads alongside it.
  - On that same edge, the accumulator reloads INIT and the state moves to HOLD.
  - Latency: crc_valid asserts on the cycle after the last beat is accepted.
- HOLD exit: on crc_ready, crc_valid drops the next cycle unless another last beat is accepted in that same cycle. In that case crc_valid stays at 1 and crc_out updates, giving back-to-back messages with no bubble.
- Result stability: crc_out and crc_match are held stable while crc_valid && !crc_ready.
- clear: has priority over all beats. The accumulator loads INIT, crc_valid drops to 0, and the state moves to ACCUM. A beat presented in the same cycle is not consumed: s_ready = 0 while clear = 1.
- Reset mid-message: partial CRC is discarded and no result is produced.
- Illegal keep: a non-contiguous keep on the last beat is undefined. An assertion in simulation only flags it.

Test Plan:
- DW=8, default CRC-32, bytes "123456789" (0x31..0x39), last on 0x39 -> one cycle later crc_valid=1, crc_out=0xCBF43926, crc_match=0.
- DW=32, beats 0x34333231, 0x38373635, 0x00000039 with keep=4'b0001 and last -> crc_out=0xCBF43926; s_ready stays at 1 throughout.
- DW=32, single last beat with keep=0 -> crc_out=0x00000000. Single last beat data=0x00 with keep=4'b0001 -> crc_out=0xD202EF8D.
- DW=8, "123456789" followed by 0x26, 0x39, 0xF4, 0xCB -> crc_out=0x2144DF1C and crc_match=1. Flip one data bit -> crc_match=0.
- Hold crc_ready=0 for 5 cycles after a result -> s_ready=0, crc_out stable. Then raise crc_ready while a new 1-byte message 0x00 is presented -> crc_valid stays at 1 and the next crc_out is 0xD202EF8D.
- Assert rst asynchronously after 4 of 9 bytes, then send "123456789" again -> no spurious crc_valid; crc_out=0xCBF43926. Repeat using clear instead of rst -> same result.
